param_divider: RTL

//   Sequential radix-2 restoring integer divider, parametrised in operand width.

---
 rtl/divider_pkg.sv | 19 +
 rtl/divider_step.sv | 35 +++
 rtl/param_divider.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
//   Shared types and constants for the parametrised restoring divider.
//   - state_t : control FSM states (IDLE -> CALC -> FIX -> IDLE)
//   - CNT_W   : step-counter width. It is sized for the widest legal operand
//               width (32) so a single package serves every WIDTH instance.
// ---------------------------------------------------------------------------
package divider_pkg;

  localparam int MAX_WIDTH = 32;
  localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage : divider_pkg

// File: rtl/divider_step.sv
// ---------------------------------------------------------------------------
// divider_step
//   One combinational radix-2 restoring step.
//   Ports:
//     rem      in   WIDTH    partial remainder (always < div between steps)
//     dvd_msb  in   1        next dividend bit shifted into the remainder
//     div      in   WIDTH    divisor magnitude
//     rem_next out  WIDTH    partial remainder after this step
//     q_bit    out  1        quotient bit produced by this step
// ---------------------------------------------------------------------------
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // The shifted remainder needs one extra bit; the compare is done at
  // WIDTH+1 bits so it cannot overflow.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] div_ext;

  always_comb begin
    rem_sh  = {rem, dvd_msb};
    div_ext = {1'b0, div};
    q_bit   = (rem_sh >= div_ext);
    // After a successful subtract, or when no subtract happens, the result
    // is below the divisor, so the top bit is always zero and can be dropped.
    rem_next = q_bit ? WIDTH'(rem_sh - div_ext) : rem_sh[WIDTH-1:0];
  end

endmodule : divider_step

// File: rtl/param_divider.sv
// ---------------------------------------------------------------------------
// param_divider
//   Sequential radix-2 restoring divider with signed/unsigned mode,
//   divide-by-zero and signed-overflow flags, and a Start/Done handshake.
//   Ports:
//     Clk          in   1      rising-edge clock
//     Reset_n      in   1      asynchronous active-low reset
//     A            in   WIDTH  dividend, sampled on the accepting edge
//     B            in   WIDTH  divisor, sampled on the accepting edge
//     Signed_Mode  in   1      1 = two's complement operands
//     Start        in   1      request, accepted in IDLE when not busy
//     DQ           out  WIDTH  quotient (held)
//     DR           out  WIDTH  remainder (held)
//     Done         out  1      one-cycle result-valid pulse
//     Busy         out  1      accepting edge through the Done cycle
//     DivZero      out  1      B was zero for the last operation
//     Overflow     out  1      signed MIN / -1 for the last operation
// ---------------------------------------------------------------------------
module param_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Signed_Mode,
  input  logic             Start,
  output logic [WIDTH-1:0] DQ,
  output logic [WIDTH-1:0] DR,
  output logic             Done,
  output logic             Busy,
  output logic             DivZero,
  output logic             Overflow
);

  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t state, state_next;

  // FSM control strobes
  logic accept, step_en, fix_en;

  // Operand decode (combinational, from the live inputs)
  logic             a_neg, b_neg, b_zero, min_by_neg1, special;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Datapath registers
  logic [WIDTH-1:0] dvd;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] div_mag;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg, dz_pend, ov_pend;

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .div      (div_mag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    a_neg       = Signed_Mode & A[WIDTH-1];
    b_neg       = Signed_Mode & B[WIDTH-1];
    // MIN negates to itself, which is exactly its unsigned magnitude.
    a_mag       = a_neg ? -A : A;
    b_mag       = b_neg ? -B : B;
    b_zero      = (B == '0);
    min_by_neg1 = Signed_Mode && (A == MIN_VAL) && (B == '1);
    special     = b_zero | min_by_neg1;
  end

  // ---- FSM: state register ----
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next
    // unassigned and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: if (Start && !Busy) state_next = special ? FIX : CALC;
      CALC: if (cnt == LAST_STEP) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- FSM: output (control strobe) logic ----
  // The Done cycle is already IDLE, but Busy is still high there, so a Start
  // in that cycle is ignored.
  always_comb begin
    accept  = (state == IDLE) && Start && !Busy;
    step_en = (state == CALC);
    fix_en  = (state == FIX);
  end

  // ---- Datapath and registered outputs ----
  // NOTE: the operand and remainder registers are plain flops, not a memory,
  // so they share the async reset and never hold X after reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dvd      <= '0;
      rem      <= '0;
      div_mag  <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz_pend  <= 1'b0;
      ov_pend  <= 1'b0;
      DQ       <= '0;
      DR       <= '0;
      Done     <= 1'b0;
      Busy     <= 1'b0;
      DivZero  <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Done <= fix_en;
      if (Done) Busy <= 1'b0;

      if (accept) begin
        // Special cases keep the raw dividend: B==0 reports it as DR.
        dvd      <= special ? A : a_mag;
        rem      <= '0;
        div_mag  <= b_mag;
        cnt      <= '0;
        q_neg    <= a_neg ^ b_neg;
        r_neg    <= a_neg;
        dz_pend  <= b_zero;
        ov_pend  <= min_by_neg1;
        DivZero  <= 1'b0;
        Overflow <= 1'b0;
        Busy     <= 1'b1;
      end else if (step_en) begin
        dvd <= {dvd[WIDTH-2:0], q_bit};
        rem <= rem_next;
        cnt <= cnt + 1'b1;
      end else if (fix_en) begin
        if (dz_pend) begin
          DQ      <= '1;
          DR      <= dvd;
          DivZero <= 1'b1;
        end else if (ov_pend) begin
          DQ       <= MIN_VAL;
          DR       <= '0;
          Overflow <= 1'b1;
        end else begin
          // Truncating division: quotient sign from the operand signs,
          // remainder takes the dividend's sign.
          DQ <= q_neg ? -dvd : dvd;
          DR <= r_neg ? -rem : rem;
        end
      end
    end
  end

endmodule : param_divider
